mem_wb_lsu: RTL and testbench
=============================

Name: mem_wb_lsu

Overview:
Memory-access stage plus MEM/WB pipeline register of the 5-stage RISC-V core, sitting directly upstream of the write-back mux. It takes EX/MEM results, performs RV32I loads and stores over a req/ack data-memory bus with byte-lane steering and sign/zero extension, and stalls the upstream pipe while the bus is busy. It raises a fault on misaligned or illegal accesses, and registers ALU result, formatted load data and control into the WB-facing outputs.

Parameters:
MAX_WAIT, 15, wait cycles tolerated after the first request cycle before aborting with a bus fault (1..255).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
VALID_MEM  in  1  EX/MEM holds a live instruction.
ALU_OUT_MEM  in  32  ALU result / effective address.
STORE_DATA_MEM  in  32  rs2 value for stores.
RD_MEM  in  5  destination register.
FUNCT3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
MemRead_MEM  in  1  load.
MemWrite_MEM  in  1  store.
MemtoReg_MEM  in  1  WB selects memory data.
RegWrite_MEM  in  1  writes register file.
STALL_MEM  out  1  freeze IF..EX/MEM this cycle.
DMEM_REQ  out  1  bus request.
DMEM_WE  out  1  1 = write.
DMEM_ADDR  out  32  word-aligned address ({addr[31:2],2'b00}).
DMEM_WDATA  out  32  lane-replicated store data.
DMEM_BE  out  4  byte enables.
DMEM_ACK  in  1  transfer complete this cycle (DMEM_RDATA valid on loads).
DMEM_RDATA  in  32  read word.
DATA_MEMORY_WB  out  32  formatted load data.
ALU_OUT_WB  out  32  registered ALU result.
MemtoReg_WB  out  1  registered.
RegWrite_WB  out  1  registered; forced 0 on bubble/fault.
RD_WB  out  5  registered.
VALID_WB  out  1  WB holds a retired instruction.
FAULT_WB  out  1  one-cycle pulse aligned with the faulting slot.
FAULT_CAUSE_WB  out  2  01 misaligned, 10 illegal, 11 bus timeout.

Behaviour:
- Reset (async assert, sync release): state IDLE, wait counter 0, every output 0 (DMEM_REQ and STALL_MEM drop immediately on assert). An in-flight transfer is abandoned; a late DMEM_ACK after release is ignored.
- States: IDLE, WAIT.
- mem_op = VALID_MEM & (MemRead_MEM | MemWrite_MEM).
- Fault check runs in IDLE, combinationally. Illegal: both MemRead and MemWrite set; store funct3 not in {000,001,010}; load funct3 in {011,110,111}. Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal wins over misaligned.
- IDLE, mem_op, no fault: DMEM_REQ=1 with address/BE/WDATA/WE driven from inputs.
  - ACK same cycle: zero-wait, no stall, retires at this edge.
  - No ACK: STALL_MEM=1; latch addr, BE, WDATA, WE, funct3, rd, control; go to WAIT; counter=0.
- WAIT: DMEM_REQ=1 from latched values, STALL_MEM=1.
  - ACK: retire at this edge, STALL_MEM=0 this cycle, go to IDLE.
  - No ACK: counter+1. When counter==MAX_WAIT with no ACK: drop REQ next cycle, retire as bubble with FAULT_CAUSE 11, go to IDLE.
- Upstream holds inputs stable while STALL_MEM=1. WB register loads a bubble (VALID_WB=0, RegWrite_WB=0, FAULT_WB=0) every stalled cycle.
- Non-memory instruction or faulted access: no bus request, no stall. Registered to WB next edge (latency 1). On fault: VALID_WB=1, RegWrite_WB=0, FAULT_WB=1 with cause.
- VALID_MEM=0: bubble.
- Stores: SB BE=1<<addr[1:0], WDATA={4{d[7:0]}}. SH BE=addr[1]?1100:0011, WDATA={2{d[15:0]}}. SW BE=1111.
- Loads: select lane by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend; W passes through.
- DATA_MEMORY_WB=0 for non-loads. ALU_OUT_WB always carries the address/result.
- Memory latency = 1 + wait cycles; throughput one op per cycle with zero-wait memory.

Test Plan:
1. Non-mem ADD (ALU_OUT=0x0000_1234, rd=5, RegWrite=1) -> next edge ALU_OUT_WB=0x1234, RD_WB=5, VALID_WB=1, STALL_MEM=0, DMEM_REQ never 1.
2. LB addr 0x103, RDATA=0x80FF_0000, ACK same cycle -> DATA_MEMORY_WB=0xFFFF_FF80, no stall; repeat as LBU -> 0x0000_0080.
3. SH addr 0x202, data 0x0000_ABCD, ACK after 3 wait cycles -> STALL_MEM high 3 cycles, BE=1100, WDATA=0xABCD_ABCD, ADDR=0x200; three bubbles then VALID_WB=1, RegWrite_WB=0.
4. LW addr 0x105 -> no request, FAULT_WB=1, cause 01, RegWrite_WB=0; MemRead&MemWrite both set -> cause 10.
5. MAX_WAIT=4, LW with ACK never asserted -> REQ high 5 cycles then low, FAULT cause 11, state IDLE, next instruction proceeds.
6. rst_n low during WAIT -> DMEM_REQ, STALL_MEM, all WB outputs 0 immediately; ACK one cycle after release produces no retirement.

Source files
------------

// File: rtl/mem_wb_lsu.sv
// RV32I memory-access stage and MEM/WB register: req/ack data bus, lane steering, load extension, access faults.
// Latency 1 + memory wait cycles; STALL_MEM holds IF..EX/MEM while a transfer is outstanding.
module mem_wb_lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VALID_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] STORE_DATA_MEM,
  input  logic [4:0]  RD_MEM,
  input  logic [2:0]  FUNCT3_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        RegWrite_MEM,
  output logic        STALL_MEM,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic [31:0] DATA_MEMORY_WB,
  output logic [31:0] ALU_OUT_WB,
  output logic        MemtoReg_WB,
  output logic        RegWrite_WB,
  output logic [4:0]  RD_WB,
  output logic        VALID_WB,
  output logic        FAULT_WB,
  output logic [1:0]  FAULT_CAUSE_WB
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_we;
  logic        lat_read;
  logic        lat_regwrite;
  logic        lat_memtoreg;
  logic [2:0]  lat_funct3;
  logic [4:0]  lat_rd;

  logic        mem_op;
  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  logic        cur_we;
  logic        cur_read;
  logic        cur_regwrite;
  logic        cur_memtoreg;
  logic [2:0]  cur_funct3;
  logic [4:0]  cur_rd;

  logic        req;
  logic        done;
  logic        timeout;
  logic [31:0] lane_word;
  logic [31:0] load_data;

  always_comb begin
    mem_op  = VALID_MEM & (MemRead_MEM | MemWrite_MEM);
    illegal = (MemRead_MEM & MemWrite_MEM)
            | (MemWrite_MEM & (FUNCT3_MEM != 3'b000) & (FUNCT3_MEM != 3'b001) & (FUNCT3_MEM != 3'b010))
            | (MemRead_MEM & ((FUNCT3_MEM == 3'b011) | (FUNCT3_MEM == 3'b110) | (FUNCT3_MEM == 3'b111)));
    misaligned = ((FUNCT3_MEM[1:0] == 2'b01) & ALU_OUT_MEM[0])
               | ((FUNCT3_MEM == 3'b010) & (ALU_OUT_MEM[1:0] != 2'b00));
    fault       = (state == IDLE) & mem_op & (illegal | misaligned);
    fault_cause = illegal ? 2'b10 : 2'b01;
  end

  always_comb begin
    in_be    = 4'b1111;
    in_wdata = STORE_DATA_MEM;
    case (FUNCT3_MEM[1:0])
      2'b00: begin
        in_be    = 4'b0001 << ALU_OUT_MEM[1:0];
        in_wdata = {4{STORE_DATA_MEM[7:0]}};
      end
      2'b01: begin
        in_be    = ALU_OUT_MEM[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{STORE_DATA_MEM[15:0]}};
      end
      default: begin
        in_be    = 4'b1111;
        in_wdata = STORE_DATA_MEM;
      end
    endcase
  end

  always_comb begin
    if (state == WAIT) begin
      cur_addr     = lat_addr;
      cur_wdata    = lat_wdata;
      cur_be       = lat_be;
      cur_we       = lat_we;
      cur_read     = lat_read;
      cur_regwrite = lat_regwrite;
      cur_memtoreg = lat_memtoreg;
      cur_funct3   = lat_funct3;
      cur_rd       = lat_rd;
    end else begin
      cur_addr     = ALU_OUT_MEM;
      cur_wdata    = in_wdata;
      cur_be       = in_be;
      cur_we       = MemWrite_MEM;
      cur_read     = MemRead_MEM;
      cur_regwrite = RegWrite_MEM;
      cur_memtoreg = MemtoReg_MEM;
      cur_funct3   = FUNCT3_MEM;
      cur_rd       = RD_MEM;
    end
  end

  // Bus request is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    req     = rst_n & ((state == WAIT) | (mem_op & ~(illegal | misaligned)));
    done    = req & DMEM_ACK;
    timeout = (state == WAIT) & ~DMEM_ACK & ((wait_cnt + 8'd1) == MAX_W);

    STALL_MEM  = req & ~DMEM_ACK & ~timeout;
    DMEM_REQ   = req;
    DMEM_WE    = req & cur_we;
    DMEM_ADDR  = req ? {cur_addr[31:2], 2'b00} : 32'h0;
    DMEM_WDATA = req ? cur_wdata : 32'h0;
    DMEM_BE    = req ? cur_be : 4'h0;
  end

  always_comb begin
    lane_word = DMEM_RDATA >> {cur_addr[1:0], 3'b000};
    case (cur_funct3)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b100:  load_data = {24'h0, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b101:  load_data = {16'h0, lane_word[15:0]};
      default: load_data = DMEM_RDATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= 8'h0;
      lat_addr       <= 32'h0;
      lat_wdata      <= 32'h0;
      lat_be         <= 4'h0;
      lat_we         <= 1'b0;
      lat_read       <= 1'b0;
      lat_regwrite   <= 1'b0;
      lat_memtoreg   <= 1'b0;
      lat_funct3     <= 3'h0;
      lat_rd         <= 5'h0;
      DATA_MEMORY_WB <= 32'h0;
      ALU_OUT_WB     <= 32'h0;
      MemtoReg_WB    <= 1'b0;
      RegWrite_WB    <= 1'b0;
      RD_WB          <= 5'h0;
      VALID_WB       <= 1'b0;
      FAULT_WB       <= 1'b0;
      FAULT_CAUSE_WB <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req && !DMEM_ACK) begin
            state        <= WAIT;
            wait_cnt     <= 8'h0;
            lat_addr     <= ALU_OUT_MEM;
            lat_wdata    <= in_wdata;
            lat_be       <= in_be;
            lat_we       <= MemWrite_MEM;
            lat_read     <= MemRead_MEM;
            lat_regwrite <= RegWrite_MEM;
            lat_memtoreg <= MemtoReg_MEM;
            lat_funct3   <= FUNCT3_MEM;
            lat_rd       <= RD_MEM;
          end
        end
        WAIT: begin
          if (DMEM_ACK || timeout) begin
            state    <= IDLE;
            wait_cnt <= 8'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Default is a bubble; stalled cycles fall through to it.
      ALU_OUT_WB     <= cur_addr;
      RD_WB          <= cur_rd;
      MemtoReg_WB    <= cur_memtoreg;
      DATA_MEMORY_WB <= 32'h0;
      RegWrite_WB    <= 1'b0;
      VALID_WB       <= 1'b0;
      FAULT_WB       <= 1'b0;
      FAULT_CAUSE_WB <= 2'b00;
      if (done) begin
        VALID_WB       <= 1'b1;
        RegWrite_WB    <= cur_regwrite;
        DATA_MEMORY_WB <= cur_read ? load_data : 32'h0;
      end else if (timeout) begin
        VALID_WB       <= 1'b1;
        FAULT_WB       <= 1'b1;
        FAULT_CAUSE_WB <= 2'b11;
      end else if (fault) begin
        VALID_WB       <= 1'b1;
        FAULT_WB       <= 1'b1;
        FAULT_CAUSE_WB <= fault_cause;
      end else if ((state == IDLE) && VALID_MEM && !mem_op) begin
        VALID_WB    <= 1'b1;
        RegWrite_WB <= RegWrite_MEM;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Randomized self-checking bench for mem_wb_lsu against a per-instruction reference model.
module tb_mem_wb_lsu;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        VALID_MEM;
  logic [31:0] ALU_OUT_MEM;
  logic [31:0] STORE_DATA_MEM;
  logic [4:0]  RD_MEM;
  logic [2:0]  FUNCT3_MEM;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic        MemtoReg_MEM;
  logic        RegWrite_MEM;
  logic        STALL_MEM;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic        DMEM_ACK;
  logic [31:0] DMEM_RDATA;
  logic [31:0] DATA_MEMORY_WB;
  logic [31:0] ALU_OUT_WB;
  logic        MemtoReg_WB;
  logic        RegWrite_WB;
  logic [4:0]  RD_WB;
  logic        VALID_WB;
  logic        FAULT_WB;
  logic [1:0]  FAULT_CAUSE_WB;

  int checks = 0;
  int errors = 0;

  mem_wb_lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .VALID_MEM(VALID_MEM), .ALU_OUT_MEM(ALU_OUT_MEM), .STORE_DATA_MEM(STORE_DATA_MEM),
    .RD_MEM(RD_MEM), .FUNCT3_MEM(FUNCT3_MEM), .MemRead_MEM(MemRead_MEM),
    .MemWrite_MEM(MemWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .RegWrite_MEM(RegWrite_MEM),
    .STALL_MEM(STALL_MEM), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .DATA_MEMORY_WB(DATA_MEMORY_WB), .ALU_OUT_WB(ALU_OUT_WB), .MemtoReg_WB(MemtoReg_WB),
    .RegWrite_WB(RegWrite_WB), .RD_WB(RD_WB), .VALID_WB(VALID_WB), .FAULT_WB(FAULT_WB),
    .FAULT_CAUSE_WB(FAULT_CAUSE_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0 = no fault, 1 misaligned, 2 illegal
  function automatic logic [1:0] model_fault(input bit rd_e, input bit wr_e, input logic [2:0] f3,
                                             input logic [31:0] addr);
    bit ill, mis;
    ill = (rd_e && wr_e) || (wr_e && f3 > 3'd2) || (rd_e && (f3 == 3'd3 || f3 >= 3'd6));
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
    if (ill) return 2'd2;
    if (mis) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    logic [31:0] w;
    w = rdata >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(w[7:0]));
      3'd4:    return w & 32'h0000_00FF;
      3'd1:    return 32'($signed(w[15:0]));
      3'd5:    return w & 32'h0000_FFFF;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input int off);
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the instruction leaves the stage.
  task automatic run_instr(input bit v, input bit rd_e, input bit wr_e, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                           input bit m2r, input bit rw, input int delay, input logic [31:0] rdata);
    logic [1:0] cause;
    bit busop, timed_out;
    int n, off;
    logic [31:0] exp_data;
    VALID_MEM = v; MemRead_MEM = rd_e; MemWrite_MEM = wr_e; FUNCT3_MEM = f3;
    ALU_OUT_MEM = addr; STORE_DATA_MEM = sd; RD_MEM = rd; MemtoReg_MEM = m2r; RegWrite_MEM = rw;
    off   = int'(addr % 4);
    cause = (v && (rd_e || wr_e)) ? model_fault(rd_e, wr_e, f3, addr) : 2'd0;
    busop = v && (rd_e || wr_e) && cause == 2'd0;
    timed_out = busop && delay > MW;
    n = busop ? ((delay > MW ? MW : delay) + 1) : 1;
    for (int k = 0; k < n; k++) begin
      DMEM_ACK   = busop && k == delay;
      DMEM_RDATA = (k == delay) ? rdata : $urandom;
      @(negedge clk);
      chk("dmem_req", DMEM_REQ, busop);
      chk("stall", STALL_MEM, busop && k < delay && k < MW);
      if (busop) begin
        chk("dmem_addr", DMEM_ADDR, addr & 32'hFFFF_FFFC);
        chk("dmem_we", DMEM_WE, wr_e);
        if (wr_e) begin
          chk("dmem_be", DMEM_BE, model_be(f3, off));
          chk("dmem_wdata", DMEM_WDATA, model_wdata(f3, sd));
        end
      end
      @(posedge clk); #1;
      if (k < n - 1) begin
        chk("bubble_valid", VALID_WB, 0);
        chk("bubble_regwrite", RegWrite_WB, 0);
        chk("bubble_fault", FAULT_WB, 0);
      end
    end
    DMEM_ACK = 1'b0;
    exp_data = (busop && !timed_out && rd_e) ? model_load(f3, off, rdata) : 32'h0;
    if (timed_out) cause = 2'd3;
    chk("valid_wb", VALID_WB, v);
    chk("fault_wb", FAULT_WB, v && cause != 2'd0);
    chk("regwrite_wb", RegWrite_WB, v && cause == 2'd0 && rw);
    chk("data_wb", DATA_MEMORY_WB, exp_data);
    if (v) begin
      chk("alu_out_wb", ALU_OUT_WB, addr);
      chk("rd_wb", RD_WB, rd);
      chk("memtoreg_wb", MemtoReg_WB, m2r);
      if (cause != 2'd0) chk("fault_cause", FAULT_CAUSE_WB, cause);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    VALID_MEM = 1'b1; MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; FUNCT3_MEM = 3'd2;
    ALU_OUT_MEM = 32'h100; STORE_DATA_MEM = 32'h0; RD_MEM = 5'd1;
    MemtoReg_MEM = 1'b1; RegWrite_MEM = 1'b1; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    #12;
    chk("rst_req", DMEM_REQ, 0);
    chk("rst_stall", STALL_MEM, 0);
    chk("rst_be", DMEM_BE, 0);
    chk("rst_valid", VALID_WB, 0);
    chk("rst_alu", ALU_OUT_WB, 0);
    chk("rst_data", DATA_MEMORY_WB, 0);
    chk("rst_fault", FAULT_WB, 0);
    VALID_MEM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases from the plan
    run_instr(1, 0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 0, 1, 0, 32'h0);
    run_instr(1, 1, 0, 3'd0, 32'h0000_0103, 32'h0, 5'd6, 1, 1, 0, 32'h80FF_0000);
    chk("lb_value", DATA_MEMORY_WB, 32'hFFFF_FF80);
    run_instr(1, 1, 0, 3'd4, 32'h0000_0103, 32'h0, 5'd6, 1, 1, 0, 32'h80FF_0000);
    chk("lbu_value", DATA_MEMORY_WB, 32'h0000_0080);
    run_instr(1, 0, 1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 0, 3, 32'h0);
    run_instr(1, 1, 0, 3'd2, 32'h0000_0105, 32'h0, 5'd7, 1, 1, 0, 32'h0);
    run_instr(1, 1, 1, 3'd2, 32'h0000_0100, 32'h0, 5'd7, 1, 1, 0, 32'h0);
    run_instr(1, 1, 0, 3'd2, 32'h0000_0300, 32'h0, 5'd8, 1, 1, 99, 32'h0);
    run_instr(1, 0, 0, 3'd0, 32'h0000_0042, 32'h0, 5'd9, 0, 1, 0, 32'h0);

    // Reset while a transfer is outstanding
    VALID_MEM = 1'b1; MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; FUNCT3_MEM = 3'd2;
    ALU_OUT_MEM = 32'h400; RD_MEM = 5'd3; DMEM_ACK = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_stall", STALL_MEM, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", DMEM_REQ, 0);
    chk("mid_rst_stall", STALL_MEM, 0);
    chk("mid_rst_valid", VALID_WB, 0);
    chk("mid_rst_alu", ALU_OUT_WB, 0);
    chk("mid_rst_rd", RD_WB, 0);
    @(posedge clk); #1;
    VALID_MEM = 1'b0;
    rst_n = 1'b1;
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_req", DMEM_REQ, 0);
    @(posedge clk); #1;
    DMEM_ACK = 1'b0;
    chk("late_ack_valid", VALID_WB, 0);
    chk("late_ack_regwrite", RegWrite_WB, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int kind, dsel, delay;
      bit v, rd_e, wr_e;
      logic [2:0] f3;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      v    = kind != 0;
      rd_e = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind >= 3 && kind <= 5) || kind == 9;
      wr_e = (kind >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (wr_e) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (f3 == 3'd1 || f3 == 3'd5) addr[0] = 1'b0;
        if (f3 == 3'd2) addr[1:0] = 2'b00;
      end
      dsel  = $urandom_range(0, 9);
      delay = (dsel < 5) ? 0 : $urandom_range(1, MW + 2);
      run_instr(v, rd_e, wr_e, f3, addr, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                delay, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
